ssd_scroller: RTL and testbench

//  Upstream feeder for the two-digit PmodSSD display controller. Buffers a message of 5-bit

---
 rtl/ssd_scroller.sv | 155 +++++++++++++++
 tb/tb_ssd_scroller.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ssd_scroller.sv
// Buffers 5-bit character codes and scrolls them right-to-left over two SSD digits.
// Define SSD_SCROLL_LOOP_EN to add the loop_en port for continuous looping.
module ssd_scroller #(
   parameter int unsigned   CLK_INPUT_FREQ_HZ = 100_000_000,
   parameter int unsigned   SCROLL_FREQ_HZ    = 4,
   parameter int unsigned   DEPTH             = 16,
   parameter logic [4:0]    BLANK_CODE        = 5'h1F,
   parameter bit            SIMULATE          = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_valid,
   input  logic [4:0] wr_data,
   output logic       wr_ready,
   input  logic       start,
   input  logic       abort,
`ifdef SSD_SCROLL_LOOP_EN
   input  logic       loop_en,
`endif
   output logic       busy,
   output logic       done,
   output logic [4:0] digit1,
   output logic [4:0] digit0
);

   localparam int unsigned PERIOD =
      SIMULATE ? 4 : CLK_INPUT_FREQ_HZ / SCROLL_FREQ_HZ;
   localparam int unsigned TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef enum logic [1:0] {
      IDLE,
      SCROLL,
      DRAIN
   } state_t;

   state_t          state;
   logic [CW-1:0]   count;
   logic [AW-1:0]   rd_idx;
   logic [TW-1:0]   tick_cnt;
   logic            drain_cnt;
   logic            gap;
   logic [4:0]      mem [DEPTH];

   logic            wr_fire;
   logic [CW-1:0]   count_nxt;
   logic            tick;
   logic            last;
   logic            loop_req;

`ifdef SSD_SCROLL_LOOP_EN
   assign loop_req = loop_en;
`else
   assign loop_req = 1'b0;
`endif

   assign wr_fire   = wr_valid && wr_ready;
   assign count_nxt = count + CW'(wr_fire);
   assign tick      = (tick_cnt == '0);
   assign last      = ({1'b0, rd_idx} == count - CW'(1));

   // Buffer storage carries no reset; count alone defines valid entries.
   always_ff @(posedge clk) begin
      if (wr_fire)
         mem[count[AW-1:0]] <= wr_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         count     <= '0;
         rd_idx    <= '0;
         tick_cnt  <= '0;
         drain_cnt <= 1'b0;
         gap       <= 1'b0;
         digit1    <= BLANK_CODE;
         digit0    <= BLANK_CODE;
         busy      <= 1'b0;
         done      <= 1'b0;
         wr_ready  <= 1'b1;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (abort) begin
                  count    <= '0;
                  wr_ready <= 1'b1;
               end else begin
                  count <= count_nxt;
                  if (start && (count_nxt != '0)) begin
                     state     <= SCROLL;
                     busy      <= 1'b1;
                     wr_ready  <= 1'b0;
                     tick_cnt  <= '0;
                     rd_idx    <= '0;
                     drain_cnt <= 1'b0;
                     gap       <= 1'b0;
                  end else begin
                     wr_ready <= (count_nxt < CW'(DEPTH));
                  end
               end
            end
            SCROLL, DRAIN: begin
               if (abort) begin
                  state    <= IDLE;
                  digit1   <= BLANK_CODE;
                  digit0   <= BLANK_CODE;
                  count    <= '0;
                  rd_idx   <= '0;
                  gap      <= 1'b0;
                  busy     <= 1'b0;
                  wr_ready <= 1'b1;
               end else begin
                  tick_cnt <= (tick_cnt == TW'(PERIOD - 1)) ?
                              '0 : tick_cnt + TW'(1);
                  if (tick) begin
                     digit1 <= digit0;
                     if (state == DRAIN) begin
                        digit0    <= BLANK_CODE;
                        drain_cnt <= 1'b1;
                        if (drain_cnt) begin
                           state    <= IDLE;
                           done     <= 1'b1;
                           count    <= '0;
                           rd_idx   <= '0;
                           busy     <= 1'b0;
                           wr_ready <= 1'b1;
                        end
                     end else if (gap) begin
                        // One blank between loop passes, then restart at entry 0.
                        digit0 <= BLANK_CODE;
                        gap    <= 1'b0;
                        rd_idx <= '0;
                     end else begin
                        digit0 <= mem[rd_idx];
                        rd_idx <= rd_idx + AW'(1);
                        if (last) begin
                           if (loop_req)
                              gap <= 1'b1;
                           else begin
                              state     <= DRAIN;
                              drain_cnt <= 1'b0;
                           end
                        end
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ssd_scroller.sv
// Directed self-checking bench for ssd_scroller.
module tb_ssd_scroller;

   logic       clk;
   logic       reset;
   logic       wr_valid;
   logic [4:0] wr_data;
   logic       wr_ready;
   logic       start;
   logic       abort;
   logic       busy;
   logic       done;
   logic [4:0] digit1;
   logic [4:0] digit0;
`ifdef SSD_SCROLL_LOOP_EN
   logic       loop_en;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   ssd_scroller dut (
      .clk      (clk),
      .reset    (reset),
      .wr_valid (wr_valid),
      .wr_data  (wr_data),
      .wr_ready (wr_ready),
      .start    (start),
      .abort    (abort),
`ifdef SSD_SCROLL_LOOP_EN
      .loop_en  (loop_en),
`endif
      .busy     (busy),
      .done     (done),
      .digit1   (digit1),
      .digit0   (digit0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_dig(input string tag, input logic [4:0] e1,
                          input logic [4:0] e0);
      chk({tag, ".d1"}, 32'(digit1), 32'(e1));
      chk({tag, ".d0"}, 32'(digit0), 32'(e0));
   endtask

   task automatic adv(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [4:0] d);
      wr_valid = 1'b1;
      wr_data  = d;
      adv(1);
      wr_valid = 1'b0;
   endtask

   task automatic go();
      start = 1'b1;
      adv(1);
      start = 1'b0;
   endtask

   initial begin
      reset    = 1'b0;
      wr_valid = 1'b0;
      wr_data  = '0;
      start    = 1'b0;
      abort    = 1'b0;
`ifdef SSD_SCROLL_LOOP_EN
      loop_en  = 1'b0;
`endif
      adv(3);
      chk_dig("rst", 5'h1F, 5'h1F);
      chk("rst.wr_ready", 32'(wr_ready), 32'd1);
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.done", 32'(done), 32'd0);
      reset = 1'b1;
      adv(1);

      // basic three-character message
      wr(5'h3); wr(5'h7); wr(5'hA);
      go();
      chk("t2.busy", 32'(busy), 32'd1);
      adv(1); chk_dig("t2.s1", 5'h1F, 5'h3);
      adv(4); chk_dig("t2.s2", 5'h3, 5'h7);
      adv(4); chk_dig("t2.s3", 5'h7, 5'hA);
      adv(4); chk_dig("t2.s4", 5'hA, 5'h1F);
      chk("t2.done_early", 32'(done), 32'd0);
      adv(4); chk_dig("t2.s5", 5'h1F, 5'h1F);
      chk("t2.done", 32'(done), 32'd1);
      chk("t2.busy_off", 32'(busy), 32'd0);
      adv(1);
      chk("t2.done_pulse", 32'(done), 32'd0);
      chk("t2.wr_ready", 32'(wr_ready), 32'd1);

      // full buffer, overflow write ignored
      for (int i = 0; i < 16; i++) wr(5'(i));
      chk("t3.full", 32'(wr_ready), 32'd0);
      wr(5'h1E);
      chk("t3.full2", 32'(wr_ready), 32'd0);
      go();
      adv(1); chk_dig("t3.s0", 5'h1F, 5'h0);
      for (int i = 1; i < 16; i++) begin
         adv(4);
         chk_dig($sformatf("t3.s%0d", i), 5'(i - 1), 5'(i));
      end
      adv(4); chk_dig("t3.tail1", 5'hF, 5'h1F);
      chk("t3.no17", 32'(done), 32'd0);
      adv(4); chk_dig("t3.tail2", 5'h1F, 5'h1F);
      chk("t3.done", 32'(done), 32'd1);
      adv(1);

      // start with empty buffer is ignored
      go();
      chk("t4.idle", 32'(busy), 32'd0);
      adv(4);
      chk("t4.idle2", 32'(busy), 32'd0);
      chk_dig("t4.hold", 5'h1F, 5'h1F);
      // write and start together
      wr_valid = 1'b1; wr_data = 5'h5; start = 1'b1;
      adv(1);
      wr_valid = 1'b0; start = 1'b0;
      chk("t4.busy", 32'(busy), 32'd1);
      adv(1); chk_dig("t4.s1", 5'h1F, 5'h5);
      adv(4); chk_dig("t4.s2", 5'h5, 5'h1F);
      adv(4); chk_dig("t4.s3", 5'h1F, 5'h1F);
      chk("t4.done", 32'(done), 32'd1);
      adv(1);

      // abort coinciding with a tick
      wr(5'h1); wr(5'h2); wr(5'h3);
      go();
      adv(1); chk_dig("t5.s1", 5'h1F, 5'h1);
      adv(4); chk_dig("t5.s2", 5'h1, 5'h2);
      adv(3);
      abort = 1'b1;
      adv(1);
      abort = 1'b0;
      chk_dig("t5.abort", 5'h1F, 5'h1F);
      chk("t5.busy", 32'(busy), 32'd0);
      chk("t5.done", 32'(done), 32'd0);
      chk("t5.wr_ready", 32'(wr_ready), 32'd1);
      adv(8);
      chk("t5.nodone", 32'(done), 32'd0);
      chk_dig("t5.quiet", 5'h1F, 5'h1F);
      wr(5'h9);
      go();
      adv(1); chk_dig("t5.r1", 5'h1F, 5'h9);
      adv(4); chk_dig("t5.r2", 5'h9, 5'h1F);
      adv(4); chk("t5.rdone", 32'(done), 32'd1);
      adv(1);

`ifdef SSD_SCROLL_LOOP_EN
      loop_en = 1'b1;
      wr(5'h4); wr(5'h5);
      go();
      adv(1); chk_dig("t6.s1", 5'h1F, 5'h4);
      adv(4); chk_dig("t6.s2", 5'h4, 5'h5);
      adv(4); chk_dig("t6.s3", 5'h5, 5'h1F);
      adv(4); chk_dig("t6.s4", 5'h1F, 5'h4);
      chk("t6.nodone", 32'(done), 32'd0);
      adv(4); chk_dig("t6.s5", 5'h4, 5'h5);
      adv(4); chk_dig("t6.s6", 5'h5, 5'h1F);
      chk("t6.busy", 32'(busy), 32'd1);
      abort = 1'b1;
      adv(1);
      abort = 1'b0;
      loop_en = 1'b0;
      chk_dig("t6.abort", 5'h1F, 5'h1F);
      chk("t6.idle", 32'(busy), 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
